mu0_mem_resp: RTL and testbench
===============================

MU0_MEM_RESP -- requirements
Module: mu0_mem_resp

Interface
REQ-001 Parameter AW, default 8, meaning implemented address bits; depth is 2^AW 16-bit words.
REQ-002 Parameter WAIT, default 2, meaning wait cycles per access (range 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memrq  input  1  CPU memory request.
REQ-006 rnw  input  1  1 = read, 0 = write; sampled with memrq.
REQ-007 addr  input  12  CPU word address.
REQ-008 wdata  input  16  CPU write data.
REQ-009 rdata  output  16  read data; valid while ready=1; held until the next read completes.
REQ-010 ready  output  1  one-cycle pulse marking access completion.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 err  output  1  sticky out-of-range flag.
REQ-013 ld_en  input  1  program-loader mode request.
REQ-014 ld_valid  input  1  loader word valid.
REQ-015 ld_data  input  16  loader word.
REQ-016 ld_ready  output  1  loader can accept a word this cycle.
REQ-017 ld_count  output  AW+1  number of words loaded since loader entry.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, RESP and LOAD.
REQ-019 In IDLE with ld_en=1, next state SHALL be LOAD; ld_count cleared to 0; ld_en wins over a simultaneous memrq.
REQ-020 In IDLE with memrq=1 and ld_en=0, addr, rnw and wdata SHALL be captured; next state WAIT with counter=WAIT-1, or RESP if WAIT=0.
REQ-021 WAIT SHALL decrement the counter each cycle and move to RESP in the cycle after counter reaches 0.
REQ-022 ready SHALL be 1 only in RESP, i.e. exactly WAIT+1 cycles after the request-sampling edge.
REQ-023 RESP SHALL always return to IDLE; a held memrq is re-sampled there, giving one idle cycle between back-to-back accesses.
REQ-024 Read: rdata SHALL be loaded with mem[captured addr[AW-1:0]] on the edge entering RESP.
REQ-025 Write: mem[captured addr[AW-1:0]] SHALL be updated with the captured wdata on the edge entering RESP; rdata unchanged.
REQ-026 Out-of-range (captured addr[11:AW] nonzero): reads SHALL return 16'h0000, writes SHALL be dropped, err SHALL set on RESP entry, ready still pulses with normal latency.
REQ-027 memrq, rnw, addr and wdata changes during WAIT/RESP SHALL be ignored (captured values used).
REQ-028 ld_en asserted during WAIT/RESP SHALL be ignored until the state returns to IDLE.
REQ-029 In LOAD, ld_ready SHALL equal (ld_count < 2^AW).
REQ-030 In LOAD, when ld_valid and ld_ready are both 1, mem[ld_count] SHALL be written with ld_data and ld_count incremented by 1.
REQ-031 In LOAD, ld_valid with ld_ready=0 (array full) SHALL be dropped with no wrap-around; ld_count saturates at 2^AW.
REQ-032 In LOAD, memrq SHALL be ignored (no ready, no queueing).
REQ-033 In LOAD, ld_en=0 SHALL return the FSM to IDLE next cycle; a word presented in that cycle is not written.
REQ-034 ld_count SHALL hold its value after LOAD exits until the next LOAD entry.
REQ-035 err SHALL clear only on reset.

Reset
REQ-036 When reset=1 on a rising edge, state SHALL become IDLE; ready=0, busy=0, err=0, ld_ready=0, rdata=16'h0000, ld_count=0, WAIT counter=0.
REQ-037 Reset SHALL override any in-flight access: a pending write is not performed and no ready pulse follows.
REQ-038 Reset SHALL NOT clear memory array contents.

Verification
REQ-039 WAIT=2: write 16'hBEEF to addr 12'h005, then read 12'h005 -> ready pulses 3 cycles after each request edge; rdata=16'hBEEF on the read ready cycle.
REQ-040 Load 3 words 16'h0001, 16'h2003, 16'h7000 via the loader, drop ld_en -> ld_count=3; CPU reads of addr 0..2 return those words in order.
REQ-041 Read addr 12'h100 (AW=8) -> ready after 3 cycles, rdata=16'h0000, err=1 and stays 1 until reset.
REQ-042 Assert memrq and ld_en together in IDLE -> LOAD entered, no ready pulse; assert ld_en during WAIT -> access completes first, LOAD entered after RESP.
REQ-043 Assert reset in the WAIT cycle of a write of 16'h1234 to addr 12'h010 -> no ready pulse; a subsequent read of 12'h010 returns the previous contents.
REQ-044 Present 257 loader words with ld_valid held high (AW=8) -> ld_count saturates at 256, ld_ready=0 after 256 writes, mem[0] unchanged by the 257th word.

Source files
------------

// File: rtl/mu0_mem_resp.sv
// MU0 word memory with configurable wait-state latency and a streaming program loader.
// A CPU access completes with a one-cycle ready pulse WAIT+1 cycles after its request edge.
module mu0_mem_resp #(
    parameter int AW   = 8,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memrq,
    input  logic          rnw,
    input  logic [11:0]   addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata,
    output logic          ready,
    output logic          busy,
    output logic          err,
    input  logic          ld_en,
    input  logic          ld_valid,
    input  logic [15:0]   ld_data,
    output logic          ld_ready,
    output logic [AW:0]   ld_count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_LOAD} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [11:0] cap_addr;
    logic        cap_rnw;
    logic [15:0] cap_wdata;
    logic        capture, enter_resp, ld_wr;

    logic [15:0] mem [DEPTH];

    // With WAIT=0 the access completes straight from IDLE, so the live inputs stand in for the captures.
    logic [11:0] acc_addr;
    logic        acc_rnw;
    logic [15:0] acc_wdata;
    logic        acc_oor;
    logic [AW-1:0] acc_idx;

    assign acc_addr  = (state == S_IDLE) ? addr  : cap_addr;
    assign acc_rnw   = (state == S_IDLE) ? rnw   : cap_rnw;
    assign acc_wdata = (state == S_IDLE) ? wdata : cap_wdata;
    assign acc_oor   = (acc_addr >> AW) != 12'd0;
    assign acc_idx   = acc_addr[AW-1:0];

    assign ready    = (state == S_RESP);
    assign busy     = (state != S_IDLE);
    assign ld_ready = (state == S_LOAD) && !ld_count[AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        capture    = 1'b0;
        enter_resp = 1'b0;
        ld_wr      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ld_en) begin
                    state_nx = S_LOAD;
                end else if (memrq) begin
                    capture = 1'b1;
                    if (WAIT == 0) begin
                        state_nx   = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx   = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_RESP: state_nx = S_IDLE;
            S_LOAD: begin
                if (!ld_en)
                    state_nx = S_IDLE;
                else if (ld_valid && ld_ready)
                    ld_wr = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            cap_addr  <= addr;
            cap_rnw   <= rnw;
            cap_wdata <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 16'h0000;
            err   <= 1'b0;
        end else if (enter_resp) begin
            if (acc_rnw)
                rdata <= acc_oor ? 16'h0000 : mem[acc_idx];
            if (acc_oor)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ld_count <= '0;
        else if (state == S_IDLE && ld_en)
            ld_count <= '0;
        else if (ld_wr)
            ld_count <= ld_count + 1'b1;
    end

    // Array has no reset; the reset gate only kills a write that is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (enter_resp && !acc_rnw && !acc_oor)
                mem[acc_idx] <= acc_wdata;
            else if (ld_wr)
                mem[ld_count[AW-1:0]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_mu0_mem_resp.sv
// Scoreboard bench for mu0_mem_resp: driver pushes expected responses, a negedge monitor checks them.
module tb_mu0_mem_resp;
    localparam int AW = 8, WAIT = 2, DEPTH = 256;

    logic        clk = 0, reset = 1;
    logic        memrq = 0, rnw = 0, ld_en = 0, ld_valid = 0;
    logic [11:0] addr = 0;
    logic [15:0] wdata = 0, ld_data = 0;
    logic [15:0] rdata;
    logic        ready, busy, err, ld_ready;
    logic [AW:0] ld_count;

    mu0_mem_resp #(.AW(AW), .WAIT(WAIT)) dut (
        .clk(clk), .reset(reset), .memrq(memrq), .rnw(rnw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err), .ld_en(ld_en),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    // reference model
    logic [15:0] mm [DEPTH];
    logic [15:0] m_rdata = 16'h0000;
    logic        m_err = 1'b0;
    int          m_ldc = 0;
    logic [15:0] ld_words[$];

    typedef struct { logic [15:0] rdata; logic err; int cyc; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: ready=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", 32'(rdata), 32'(mon_e.rdata));
                chk("err", 32'(err), 32'(mon_e.err));
                chk("latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issues one access; returns at the negedge after the request edge (state WAIT).
    task automatic access(input logic r, input logic [11:0] a, input logic [15:0] w);
        logic oor;
        wait_idle();
        memrq = 1; rnw = r; addr = a; wdata = w;
        oor = (a[11:8] != 4'd0);
        if (r) m_rdata = oor ? 16'h0000 : mm[a[7:0]];
        else if (!oor) mm[a[7:0]] = w;
        if (oor) m_err = 1'b1;
        sb.push_back('{m_rdata, m_err, cyc + 1 + WAIT});
        @(negedge clk);
        memrq = 0; rnw = 1'($urandom); addr = 12'($urandom); wdata = 16'($urandom);
    endtask

    task automatic load(input int n);
        wait_idle();
        ld_en = 1;
        @(negedge clk);
        m_ldc = 0;
        chk("ld_count_entry", 32'(ld_count), 32'd0);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1;
            ld_data = (i < ld_words.size()) ? ld_words[i] : 16'($urandom);
            chk("ld_ready", 32'(ld_ready), 32'(m_ldc < DEPTH));
            if (m_ldc < DEPTH) begin
                mm[m_ldc] = ld_data;
                m_ldc++;
            end
            @(negedge clk);
        end
        ld_en = 0;
        ld_valid = 1;
        ld_data = 16'($urandom);
        @(negedge clk);
        ld_valid = 0;
        chk("ld_count_exit", 32'(ld_count), 32'(m_ldc));
        chk("busy_after_load", 32'(busy), 32'd0);
    endtask

    task automatic reset_checks();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ld_count", 32'(ld_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] old10;
        repeat (3) @(negedge clk);
        reset = 0;
        reset_checks();

        // fill the whole array; the 257th word must be dropped
        ld_words = {};
        load(257);
        chk("ld_count_sat", 32'(ld_count), 32'd256);
        access(1, 12'h000, 16'h0);

        access(0, 12'h005, 16'hBEEF);
        access(1, 12'h005, 16'h0);

        // reset during the WAIT of a write kills the write and its ready
        old10 = mm[8'h10];
        wait_idle();
        memrq = 1; rnw = 0; addr = 12'h010; wdata = 16'h1234;
        @(negedge clk);
        memrq = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        m_rdata = 16'h0000; m_err = 1'b0; m_ldc = 0;
        reset_checks();
        access(1, 12'h010, 16'h0);
        wait_idle();
        chk("rst_kept_mem", 32'(mm[8'h10]), 32'(old10));

        ld_words = {16'h0001, 16'h2003, 16'h7000};
        load(3);
        access(1, 12'h000, 16'h0);
        access(1, 12'h001, 16'h0);
        access(1, 12'h002, 16'h0);

        // ld_en beats a simultaneous memrq
        wait_idle();
        memrq = 1; rnw = 1; addr = 12'h005; ld_en = 1;
        @(negedge clk);
        memrq = 0;
        chk("prio_busy", 32'(busy), 32'd1);
        chk("prio_ld_ready", 32'(ld_ready), 32'd1);
        chk("prio_ld_count", 32'(ld_count), 32'd0);
        ld_en = 0;
        m_ldc = 0;
        @(negedge clk);

        // ld_en raised mid-access waits for the access to finish
        access(1, 12'h007, 16'h0);
        ld_en = 1;
        wait_idle();
        @(negedge clk);
        chk("late_ld_ready", 32'(ld_ready), 32'd1);
        chk("late_sb_drained", sb.size(), 0);
        ld_en = 0;
        @(negedge clk);

        access(1, 12'h100, 16'h0);
        access(0, 12'h200, 16'hDEAD);
        access(1, 12'h000, 16'h0);

        for (int i = 0; i < 60; i++) begin
            access(1'($urandom), ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 255)),
                   16'($urandom));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("err_sticky", 32'(err), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
